// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO and runs mult/div as fixed-latency ops.
// The result is computed at start and held until the busy countdown commits it.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDUOp,
    input  logic        E_Valid,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_UseMDU,
    output logic        E_Start,
    output logic        E_Busy,
    output logic        MDU_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_res_hi, r_res_lo;
    logic [31:0] r_hi, r_lo;
    logic        r_wr;

    logic signed [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a, w_abs_b, w_den_s, w_den_u;
    logic [31:0] w_qs_mag, w_rs_mag, w_qu, w_ru;
    logic [31:0] w_res_hi, w_res_lo;
    logic        w_is_arith, w_is_div, w_dz;

    assign w_is_arith = (E_MDUOp >= 3'd1) && (E_MDUOp <= 3'd4);
    assign w_is_div   = (E_MDUOp == 3'd3) || (E_MDUOp == 3'd4);
    assign w_dz       = w_is_div && (E_B == 32'd0);

    assign E_Start   = E_Valid && w_is_arith && (r_state == IDLE);
    assign E_Busy    = (r_state == BUSY);
    assign MDU_Stall = D_UseMDU && (E_Start || E_Busy);
    assign HI        = r_hi;
    assign LO        = r_lo;

    assign w_prod_s = $signed(E_A) * $signed(E_B);
    assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};

    // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow and keeps
    // quotient truncation toward zero. Zero divisors are replaced so no X appears.
    assign w_abs_a  = E_A[31] ? (32'd0 - E_A) : E_A;
    assign w_abs_b  = E_B[31] ? (32'd0 - E_B) : E_B;
    assign w_den_s  = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_den_u  = (E_B == 32'd0) ? 32'd1 : E_B;
    assign w_qs_mag = w_abs_a / w_den_s;
    assign w_rs_mag = w_abs_a % w_den_s;
    assign w_qu     = E_A / w_den_u;
    assign w_ru     = E_A % w_den_u;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (E_MDUOp)
            3'd1: {w_res_hi, w_res_lo} = w_prod_s;
            3'd2: {w_res_hi, w_res_lo} = w_prod_u;
            3'd3: begin
                w_res_lo = (E_A[31] ^ E_B[31]) ? (32'd0 - w_qs_mag) : w_qs_mag;
                w_res_hi = E_A[31] ? (32'd0 - w_rs_mag) : w_rs_mag;
            end
            3'd4: begin
                w_res_lo = w_qu;
                w_res_hi = w_ru;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_wr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (E_Start) begin
                        r_res_hi <= w_res_hi;
                        r_res_lo <= w_res_lo;
                        r_wr     <= ~w_dz;
                        r_cnt    <= w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        r_state  <= BUSY;
                    end else if (E_Valid && (E_MDUOp == 3'd5)) begin
                        r_hi <= E_A;
                    end else if (E_Valid && (E_MDUOp == 3'd6)) begin
                        r_lo <= E_A;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd1) begin
                        if (r_wr) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_cnt   <= 4'd0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
